// File: rtl/cm_dcnt.sv
// cm_dcnt: loaded down-counter with repeat loop.
// A start pulse in IDLE loads a trip count (beats per pass) and a repeat
// count (passes). Each valid beat in RUN decrements O_cnt; when a pass ends
// the counter reloads from the latched trip count without a bubble. After
// the final beat the block spends one cycle in DONE pulsing O_done.
module cm_dcnt #(
   parameter int C_WIDTH     = 8,
   parameter int C_RPT_WIDTH = 8
) (
   input  logic                   I_clk,
   input  logic                   I_rst_n,
   input  logic                   I_start,
   input  logic                   I_cnt_valid,
   input  logic [C_WIDTH-1:0]     I_cnt_upper,
   input  logic [C_RPT_WIDTH-1:0] I_rpt_num,
   output logic                   O_busy,
   output logic [C_WIDTH-1:0]     O_cnt,
   output logic [C_RPT_WIDTH-1:0] O_rpt,
   output logic                   O_zero_flag,
   output logic                   O_last,
   output logic                   O_done
);

   localparam logic [C_WIDTH-1:0]     ZERO_CNT = {C_WIDTH{1'b0}};
   localparam logic [C_WIDTH-1:0]     ONE_CNT  = C_WIDTH'(1);
   localparam logic [C_RPT_WIDTH-1:0] ZERO_RPT = {C_RPT_WIDTH{1'b0}};
   localparam logic [C_RPT_WIDTH-1:0] ONE_RPT  = C_RPT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                   state_r;
   logic [C_WIDTH-1:0]       upper_r;
   logic [C_WIDTH-1:0]       cnt_r;
   logic [C_RPT_WIDTH-1:0]   rpt_r;
   logic                     busy_r;
   logic                     done_r;
   logic                     zero_flag_s;
   logic                     last_s;

   // Control FSM: load on start, count down per valid beat, reload per pass, pulse done.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state_r <= ST_IDLE;
         upper_r <= ZERO_CNT;
         cnt_r   <= ZERO_CNT;
         rpt_r   <= ZERO_RPT;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               if (I_start) begin
                  upper_r <= I_cnt_upper;
                  if ((I_cnt_upper == ZERO_CNT) || (I_rpt_num == ZERO_RPT)) begin
                     // Zero-length run: nothing to count, report completion next cycle.
                     cnt_r   <= ZERO_CNT;
                     rpt_r   <= ZERO_RPT;
                     done_r  <= 1'b1;
                     state_r <= ST_DONE;
                  end else begin
                     cnt_r   <= I_cnt_upper - ONE_CNT;
                     rpt_r   <= I_rpt_num - ONE_RPT;
                     busy_r  <= 1'b1;
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (I_cnt_valid) begin
                  if (cnt_r != ZERO_CNT) begin
                     cnt_r <= cnt_r - ONE_CNT;
                  end else if (rpt_r != ZERO_RPT) begin
                     // End of a pass with passes remaining: seamless reload.
                     cnt_r <= upper_r - ONE_CNT;
                     rpt_r <= rpt_r - ONE_RPT;
                  end else begin
                     cnt_r   <= ZERO_CNT;
                     rpt_r   <= ZERO_RPT;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= ST_DONE;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= ZERO_CNT;
               rpt_r   <= ZERO_RPT;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // End-of-pass and end-of-run flags decoded from registered state only.
   always_comb begin
      zero_flag_s = busy_r && (cnt_r == ZERO_CNT);
      last_s      = zero_flag_s && (rpt_r == ZERO_RPT);
   end

   assign O_busy      = busy_r;
   assign O_cnt       = cnt_r;
   assign O_rpt       = rpt_r;
   assign O_done      = done_r;
   assign O_zero_flag = zero_flag_s;
   assign O_last      = last_s;

endmodule

// File: tb/tb_cm_dcnt.sv
// Testbench for cm_dcnt: stimulus pushes expected beat/done events into a
// queue; a negedge monitor pops and compares whenever the DUT consumes a beat
// or pulses O_done.
module tb_cm_dcnt;

   logic       I_clk;
   logic       I_rst_n;
   logic       I_start;
   logic       I_cnt_valid;
   logic [7:0] I_cnt_upper;
   logic [7:0] I_rpt_num;
   logic       O_busy;
   logic [7:0] O_cnt;
   logic [7:0] O_rpt;
   logic       O_zero_flag;
   logic       O_last;
   logic       O_done;

   typedef struct packed {
      logic       kind;   // 0 = beat, 1 = done
      logic [7:0] cnt;
      logic [7:0] rpt;
      logic       zf;
      logic       last;
      logic       busy;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk   = 0;
   int  n_pass  = 0;
   int  cyc     = 0;
   int  trig_cyc = -10;
   bit  mon_en  = 1'b0;

   cm_dcnt #(.C_WIDTH(8), .C_RPT_WIDTH(8)) dut (
      .I_clk       (I_clk),
      .I_rst_n     (I_rst_n),
      .I_start     (I_start),
      .I_cnt_valid (I_cnt_valid),
      .I_cnt_upper (I_cnt_upper),
      .I_rpt_num   (I_rpt_num),
      .O_busy      (O_busy),
      .O_cnt       (O_cnt),
      .O_rpt       (O_rpt),
      .O_zero_flag (O_zero_flag),
      .O_last      (O_last),
      .O_done      (O_done)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push_beat(input int c, input int r);
      ev_t e;
      e.kind = 1'b0; e.cnt = 8'(c); e.rpt = 8'(r);
      e.zf = (c == 0); e.last = (c == 0) && (r == 0); e.busy = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      ev_t e;
      e.kind = 1'b1; e.cnt = 8'd0; e.rpt = 8'd0; e.zf = 1'b0; e.last = 1'b0; e.busy = 1'b0;
      exp_q.push_back(e);
   endtask

   // Expected beats of a full run: passes count down, beats within a pass count down.
   task automatic push_run(input int upper, input int rpt);
      for (int r = rpt - 1; r >= 0; r--)
         for (int c = upper - 1; c >= 0; c--)
            push_beat(c, r);
      push_done();
   endtask

   task automatic take(input ev_t act);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: got kind=%0d cnt=%0d rpt=%0d expected none (cyc %0d)",
                  act.kind, act.cnt, act.rpt, cyc);
      end else begin
         e = exp_q.pop_front();
         if (act == e) n_pass++;
         else $display("FAIL event: got kind=%0d cnt=%0d rpt=%0d zf=%0d last=%0d busy=%0d expected kind=%0d cnt=%0d rpt=%0d zf=%0d last=%0d busy=%0d (cyc %0d)",
                       act.kind, act.cnt, act.rpt, act.zf, act.last, act.busy,
                       e.kind, e.cnt, e.rpt, e.zf, e.last, e.busy, cyc);
      end
   endtask

   // Monitor: a beat is a RUN cycle with valid high; done must follow its trigger by one cycle.
   always @(negedge I_clk) begin
      ev_t a;
      if (mon_en) begin
         cyc++;
         a.cnt = O_cnt; a.rpt = O_rpt; a.zf = O_zero_flag; a.last = O_last; a.busy = O_busy;
         if (O_busy && I_cnt_valid) begin
            a.kind = 1'b0;
            take(a);
            trig_cyc = cyc;
         end else if (!O_busy && !O_done && I_start && I_rst_n) begin
            trig_cyc = cyc;
         end
         if (O_done) begin
            a.kind = 1'b1;
            take(a);
            chk("done_latency", cyc - trig_cyc, 1);
         end
      end
   end

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic start(input int upper, input int rpt);
      I_cnt_upper = 8'(upper);
      I_rpt_num   = 8'(rpt);
      I_start     = 1'b1;
      tick();
      I_start     = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (O_done) break;
         tick();
      end
      n_chk++;
      if (O_done) n_pass++;
      else $display("FAIL %s_timeout: got no O_done expected O_done within %0d cycles", name, budget);
      tick();
   endtask

   int t1_cnt[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
   int t1_rpt[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
   bit t2_val[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      I_rst_n = 1'b0; I_start = 1'b0; I_cnt_valid = 1'b0;
      I_cnt_upper = 8'd0; I_rpt_num = 8'd0;
      tick(); tick();
      mon_en = 1'b1;
      chk("rst_busy", O_busy, 0);
      chk("rst_cnt", O_cnt, 0);
      chk("rst_rpt", O_rpt, 0);
      chk("rst_done", O_done, 0);
      chk("rst_zf", O_zero_flag, 0);
      chk("rst_last", O_last, 0);
      I_rst_n = 1'b1;
      tick();

      // 1: upper=4, rpt=2, valid held high.
      for (int i = 0; i < 8; i++) push_beat(t1_cnt[i], t1_rpt[i]);
      push_done();
      I_cnt_valid = 1'b1;
      start(4, 2);
      wait_done("t1", 20);
      chk("t1_queue_empty", exp_q.size(), 0);

      // 2: upper=3, rpt=1, valid pattern 1,0,0,1,1.
      I_cnt_valid = 1'b0;
      push_run(3, 1);
      start(3, 1);
      for (int i = 0; i < 5; i++) begin
         I_cnt_valid = t2_val[i];
         tick();
         if (!t2_val[i]) chk("t2_hold_cnt", O_cnt, 1);
      end
      chk("t2_done", O_done, 1);
      I_cnt_valid = 1'b0;
      tick();
      chk("t2_queue_empty", exp_q.size(), 0);

      // 3: zero-length starts.
      I_cnt_valid = 1'b1;
      push_done();
      start(0, 5);
      chk("t3a_done", O_done, 1);
      chk("t3a_busy", O_busy, 0);
      chk("t3a_cnt", O_cnt, 0);
      tick();
      push_done();
      start(7, 0);
      chk("t3b_done", O_done, 1);
      chk("t3b_busy", O_busy, 0);
      chk("t3b_cnt", O_cnt, 0);
      tick();
      chk("t3_queue_empty", exp_q.size(), 0);

      // 4: upper=1, rpt=3.
      push_run(1, 3);
      start(1, 3);
      wait_done("t4", 10);
      chk("t4_queue_empty", exp_q.size(), 0);

      // 5a: mid-run reload attempt is ignored.
      push_run(5, 2);
      start(5, 2);
      tick(); tick();
      I_cnt_upper = 8'd9;
      I_start = 1'b1;
      tick();
      I_start = 1'b0;
      wait_done("t5a", 30);
      chk("t5a_queue_empty", exp_q.size(), 0);

      // 5b: reset mid-run while O_cnt==2.
      push_beat(4, 1);
      push_beat(3, 1);
      start(5, 2);
      tick(); tick();
      chk("t5b_cnt_before_rst", O_cnt, 2);
      I_cnt_valid = 1'b0;
      I_rst_n = 1'b0;
      tick();
      I_rst_n = 1'b1;
      chk("t5b_busy", O_busy, 0);
      chk("t5b_cnt", O_cnt, 0);
      chk("t5b_rpt", O_rpt, 0);
      chk("t5b_done", O_done, 0);
      I_cnt_valid = 1'b1;
      tick();
      chk("t5b_idle_busy", O_busy, 0);
      chk("t5b_idle_done", O_done, 0);
      tick();
      chk("t5b_queue_empty", exp_q.size(), 0);

      // 6: maximum trip count.
      push_run(255, 1);
      start(255, 1);
      chk("t6_first_cnt", O_cnt, 254);
      wait_done("t6", 300);
      chk("t6_cnt_after", O_cnt, 0);
      chk("t6_queue_empty", exp_q.size(), 0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cm_dcnt.md
Name: cm_dcnt

Overview:
- Loaded down-counter with repeat loop; the counterpart to the free-running up-counter used for CNN loop indexing.
- A control FSM loads a trip count and repeat count with a start pulse. The block counts down to zero on each valid beat, reloads for each repeat, and signals completion.
- Used by the ibuf/obuf read sequencers to produce remaining-beat indices and end-of-burst strobes.

Parameters:
C_WIDTH, 8, width of inner trip count and O_cnt
C_RPT_WIDTH, 8, width of repeat count and O_rpt

Ports:
I_clk  input  1  clock
I_rst_n  input  1  synchronous reset, active-low
I_start  input  1  load pulse; sampled only in IDLE
I_cnt_valid  input  1  decrement enable, one beat per cycle while high
I_cnt_upper  input  C_WIDTH  inner trip count (number of beats per pass), sampled at I_start
I_rpt_num  input  C_RPT_WIDTH  number of passes, sampled at I_start
O_busy  output  1  high in RUN
O_cnt  output  C_WIDTH  remaining beats in current pass minus 1 (down index)
O_rpt  output  C_RPT_WIDTH  remaining passes after current one
O_zero_flag  output  1  O_busy && O_cnt==0 (current beat is last of pass)
O_last  output  1  O_zero_flag && O_rpt==0 (current beat is last overall)
O_done  output  1  one-cycle pulse after final beat or zero-length start

Behaviour:
- Reset (I_rst_n==0 at posedge, any state including mid-run): state=IDLE; O_cnt=0, O_rpt=0, O_busy=0, O_done=0; latched upper=0. O_zero_flag=0 and O_last=0 follow combinationally.
- States: IDLE, RUN, DONE. All registers update on the posedge of I_clk.
- IDLE, I_start=1:
  - Latch S_upper=I_cnt_upper.
  - If I_cnt_upper==0 or I_rpt_num==0: go to DONE; O_cnt and O_rpt stay 0.
  - Otherwise: O_cnt=I_cnt_upper-1, O_rpt=I_rpt_num-1, go to RUN.
- IDLE, I_start=0: hold.
- RUN, I_cnt_valid=0: hold all registers; no timeout.
- RUN, I_cnt_valid=1:
  - If O_cnt!=0: O_cnt=O_cnt-1.
  - Else if O_rpt!=0: O_cnt=S_upper-1, O_rpt=O_rpt-1. This is a seamless reload with no bubble.
  - Else: go to DONE; O_cnt=0, O_rpt=0.
- DONE: O_done=1 for exactly this one cycle, then unconditionally go to IDLE. O_busy=0.
- I_start is ignored in RUN and DONE; a new start is accepted no earlier than the cycle after DONE.
- I_cnt_upper and I_rpt_num changes after load have no effect on the current run.
- I_cnt_valid outside RUN is ignored.
- Upper==1: O_zero_flag is constant 1 throughout RUN, and every valid beat reloads and decrements O_rpt.
- Max counts: Upper=2^C_WIDTH-1 and rpt=2^C_RPT_WIDTH-1 are legal. Arithmetic is modulo width, but no wrap occurs because decrement happens only when the value is nonzero.
- Total valid beats consumed per run = upper*rpt.
- Latency: last valid beat to O_done = 1 cycle.
- O_zero_flag and O_last are combinational from registered state only; there is no input-to-output combinational path.
- Registered outputs: O_cnt, O_rpt, O_busy, O_done.

Test Plan:
1. Reset, then start with upper=4, rpt=2, valid held high:
   - O_cnt sequence 3,2,1,0,3,2,1,0.
   - O_rpt=1 for the first 4 beats, 0 for the next 4.
   - O_zero_flag high on beats 4 and 8; O_last only on beat 8.
   - O_done pulses 1 cycle after beat 8; O_busy low on that cycle.
2. Start with upper=3, rpt=1, valid pattern 1,0,0,1,1:
   - O_cnt 2→1 (hold, hold) →0.
   - O_done on the cycle after the 5th valid cycle.
   - Exactly 3 beats consumed.
3. Zero-length start (upper=0, rpt=5) and, separately, (upper=7, rpt=0):
   - Next cycle O_done=1, O_busy never high, O_cnt=0.
4. Upper=1, rpt=3, valid high:
   - O_zero_flag=1 on all 3 beats; O_rpt 2,1,0.
   - O_done after beat 3.
5. Robustness within a single run (upper=5, rpt=2):
   - Mid-run: change I_cnt_upper to 9 and pulse I_start → run unaffected, 10 beats total.
   - Next run: pulse I_rst_n=0 one cycle while O_cnt=2 → next cycle IDLE, all outputs 0, no O_done.
6. C_WIDTH=8, upper=255, rpt=1:
   - O_cnt starts at 254, reaches 0 after 254 beats.
   - O_done after beat 255; no wrap to 255.
